// File: rtl/core_pkg.sv
// Shared core definitions: default widths, reset fetch address, the NOP
// encoding presented when no instruction is available, and fetch run state.
package core_pkg;

   localparam int          ADDR_W_DEF   = 32;
   localparam int          DATA_W_DEF   = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] INST_NOP     = 32'h0000_0013;

   // Fetch is held off for one cycle after reset release.
   typedef enum logic {
      PF_IDLE = 1'b0,
      PF_RUN  = 1'b1
   } pf_state_e;

endpackage

// File: rtl/pf_fifo.sv
// Prefetch queue: DEPTH entries of {addr, data}, in-order, with flush.
// Pointers wrap modulo DEPTH so non-power-of-two depths work.
module pf_fifo #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count
);

   localparam int              PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Pointer and occupancy control; flush empties the queue in one edge.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful while counted.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch front end: sequential requests on the instruction bus,
// a prefetch queue for returned words, and a valid/ready head to decode.
// A jump flushes the queue, drops any response due that cycle and redirects pc.
module if_prefetch_unit
   import core_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              fetch_req_o,
   input  logic              fetch_gnt_i,
   output logic [ADDR_W-1:0] pc_o,
   input  logic [DATA_W-1:0] ins_i,
   output logic              ins_valid_o,
   input  logic              ins_ready_i,
   output logic [DATA_W-1:0] ins_o,
   output logic [ADDR_W-1:0] ins_addr_o,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i
);

   localparam int                CNT_W      = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
   localparam logic [DATA_W-1:0] NOP        = DATA_W'(INST_NOP);

   pf_state_e         state;
   pf_state_e         state_next;
   logic [ADDR_W-1:0] pc_p0;
   logic              req_vld_p1;
   logic [ADDR_W-1:0] req_addr_p1;
   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    occ;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              valid;
   logic              pop;
   logic              push;
   logic              accept;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return a & ALIGN_MASK;
   endfunction

   assign valid  = (count != '0);
   assign pop    = valid & ins_ready_i & ~jump_flag_i;
   assign push   = req_vld_p1 & ~jump_flag_i;
   assign occ    = {1'b0, count} + {{CNT_W{1'b0}}, req_vld_p1};
   assign accept = fetch_req_o & fetch_gnt_i;

   // Run state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= PF_IDLE;
      else        state <= state_next;
   end

   // Issue only when the queue plus the in-flight word leaves room for it.
   always_comb begin
      state_next  = PF_RUN;
      fetch_req_o = 1'b0;
      if (state == PF_RUN && !jump_flag_i) begin
         if (occ < DEPTH_C || (occ == DEPTH_C && pop)) fetch_req_o = 1'b1;
      end
   end

   // Fetch pc and in-flight flag; a jump overrides sequential advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_p0      <= RESET_PC;
         req_vld_p1 <= 1'b0;
      end else begin
         req_vld_p1 <= accept;
         if (jump_flag_i)  pc_p0 <= word_align(jump_addr_i);
         else if (accept)  pc_p0 <= pc_p0 + PC_STEP;
      end
   end

   // Address travelling with the in-flight request.
   always_ff @(posedge clk) begin
      if (accept) req_addr_p1 <= pc_p0;
   end

   pf_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .flush     (jump_flag_i),
      .push_addr (req_addr_p1),
      .push_data (ins_i),
      .head_addr (head_addr),
      .head_data (head_data),
      .count     (count)
   );

   assign pc_o        = pc_p0;
   assign ins_valid_o = valid;
   assign ins_o       = valid ? head_data : NOP;
   assign ins_addr_o  = valid ? head_addr : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: three instances (DEPTH 4, 2, 16) share the
// stimulus; a queue-level model predicts every output each cycle, and
// directed literal checks pin the key cycle-by-cycle values.
module tb_if_prefetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        gnt;
   logic        ready;
   logic        jump;
   logic [31:0] jaddr;

   logic        req    [3];
   logic [31:0] pc     [3];
   logic [31:0] ins_in [3];
   logic        vld    [3];
   logic [31:0] ins    [3];
   logic [31:0] iaddr  [3];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   function automatic int dep(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 16;
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int D = (k == 0) ? 4 : (k == 1) ? 2 : 16;
      if_prefetch_unit #(
         .ADDR_W   (32),
         .DATA_W   (32),
         .DEPTH    (D),
         .RESET_PC (32'h0)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .fetch_req_o (req[k]),
         .fetch_gnt_i (gnt),
         .pc_o        (pc[k]),
         .ins_i       (ins_in[k]),
         .ins_valid_o (vld[k]),
         .ins_ready_i (ready),
         .ins_o       (ins[k]),
         .ins_addr_o  (iaddr[k]),
         .jump_flag_i (jump),
         .jump_addr_i (jaddr)
      );
   end

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d (depth %0d) at %0t: got %h, expected %h",
                  name, k, dep(k), $time, act, exp);
      end
   endtask

   task automatic go(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Instruction ROM: answers an accepted request one cycle later,
   // otherwise presents junk that must never be queued.
   logic        racc  [3];
   logic [31:0] raddr [3];
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         racc[k]  = req[k] & gnt;
         raddr[k] = pc[k];
      end
   end
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++)
         ins_in[k] = racc[k] ? rom(raddr[k]) : (32'hBAD0_0000 | 32'(k));
   end

   // Model: expected queue of addresses, one pending request, next fetch pc.
   logic [31:0] mq [3][$];
   bit          m_ok = 1'b0;
   bit          m_run   [3];
   bit          m_pend  [3];
   logic [31:0] m_paddr [3];
   logic [31:0] m_pc    [3];

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         bit          e_vld;
         bit          e_pop;
         bit          e_req;
         int          occ;
         logic [31:0] e_head;
         e_vld  = (mq[k].size() > 0);
         e_head = 32'h0;
         if (e_vld) e_head = mq[k][0];
         e_pop  = e_vld && ready && !jump;
         occ    = mq[k].size() + (m_pend[k] ? 1 : 0);
         e_req  = m_run[k] && !jump && (occ < dep(k) || (occ == dep(k) && e_pop));
         if (m_ok) begin
            check("fetch_req", k, 32'(req[k]), 32'(e_req));
            check("pc", k, pc[k], m_pc[k]);
            check("ins_valid", k, 32'(vld[k]), 32'(e_vld));
            check("ins_addr", k, iaddr[k], e_vld ? e_head : 32'h0);
            check("ins", k, ins[k], e_vld ? rom(e_head) : NOP);
         end
         if (!rst_n) begin
            mq[k].delete();
            m_pend[k] = 1'b0;
            m_pc[k]   = 32'h0;
            m_run[k]  = 1'b0;
         end else begin
            m_run[k] = 1'b1;
            if (jump) begin
               mq[k].delete();
               m_pend[k] = 1'b0;
               m_pc[k]   = {jaddr[31:2], 2'b00};
            end else begin
               if (e_pop) void'(mq[k].pop_front());
               if (m_pend[k]) mq[k].push_back(m_paddr[k]);
               m_pend[k]  = e_req && gnt;
               m_paddr[k] = m_pc[k];
               if (e_req && gnt) m_pc[k] = m_pc[k] + 32'd4;
            end
         end
      end
      m_ok = 1'b1;
   end

   initial begin
      rst_n = 1'b0;
      gnt   = 1'b1;
      ready = 1'b1;
      jump  = 1'b0;
      jaddr = 32'h0;
      for (int k = 0; k < 3; k++) ins_in[k] = 32'h0;

      // Reset held, then streaming from release
      go(3);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_req", k, 32'(req[k]), 32'h0);
         check("rst_valid", k, 32'(vld[k]), 32'h0);
         check("rst_ins", k, ins[k], 32'h0000_0013);
         check("rst_addr", k, iaddr[k], 32'h0);
         check("rst_pc", k, pc[k], 32'h0);
      end
      go(1);
      rst_n = 1'b1;
      @(negedge clk);
      check("release_req", 0, 32'(req[0]), 32'h0);
      go(1);
      @(negedge clk);
      check("first_req", 0, 32'(req[0]), 32'h1);
      check("first_pc", 0, pc[0], 32'h0);
      go(1);
      @(negedge clk);
      check("second_pc", 0, pc[0], 32'h4);
      go(1);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("stream_vld_c3", k, 32'(vld[k]), 32'h1);
         check("stream_addr_c3", k, iaddr[k], 32'h0);
         check("stream_ins_c3", k, ins[k], 32'h5A00_0000);
      end
      go(1);
      @(negedge clk);
      check("stream_addr_c4", 0, iaddr[0], 32'h4);
      check("stream_ins_c4", 0, ins[0], 32'h5A00_0004);
      go(8);

      // Bus hold in cycles 2..5 after a fresh reset
      rst_n = 1'b0;
      go(1);
      rst_n = 1'b1;
      go(2);
      gnt = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         check("hold_req", 0, 32'(req[0]), 32'h1);
         check("hold_pc", 0, pc[0], 32'h4);
         go(1);
      end
      gnt = 1'b1;
      go(2);
      @(negedge clk);
      check("hold_resume_addr", 0, iaddr[0], 32'h4);
      go(1);
      @(negedge clk);
      check("hold_next_addr", 0, iaddr[0], 32'h8);
      go(3);

      // Decode hold from release: queue fills, then drains in order
      rst_n = 1'b0;
      ready = 1'b0;
      go(1);
      rst_n = 1'b1;
      go(12);
      @(negedge clk);
      check("full_req", 0, 32'(req[0]), 32'h0);
      check("full_pc", 0, pc[0], 32'h10);
      check("full_head", 0, iaddr[0], 32'h0);
      check("model_full_pc", 0, m_pc[0], 32'h10);
      check("model_full_size", 0, 32'(mq[0].size()), 32'h4);
      check("full_pc_d2", 1, pc[1], 32'h8);
      go(1);
      ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("drain_vld", 0, 32'(vld[0]), 32'h1);
         check("drain_addr", 0, iaddr[0], 32'(4 * i));
         go(1);
      end
      go(3);

      // Jump with one in flight and three queued
      ready = 1'b0;
      go(2);
      jump  = 1'b1;
      jaddr = 32'h0000_0103;
      @(negedge clk);
      check("jump_req", 0, 32'(req[0]), 32'h0);
      go(1);
      jump  = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      check("jump_vld_t1", 0, 32'(vld[0]), 32'h0);
      check("jump_pc_t1", 0, pc[0], 32'h100);
      check("jump_req_t1", 0, 32'(req[0]), 32'h1);
      go(1);
      @(negedge clk);
      check("jump_vld_t2", 0, 32'(vld[0]), 32'h0);
      go(1);
      @(negedge clk);
      check("jump_vld_t3", 0, 32'(vld[0]), 32'h1);
      check("jump_addr_t3", 0, iaddr[0], 32'h100);
      check("jump_ins_t3", 0, ins[0], 32'h5A00_0100);
      go(1);

      // Jump held for two cycles with a changing target
      jump  = 1'b1;
      jaddr = 32'h0000_01FE;
      go(1);
      jaddr = 32'h0000_0200;
      go(1);
      jump = 1'b0;
      @(negedge clk);
      check("rejump_pc", 0, pc[0], 32'h200);
      check("rejump_vld", 0, 32'(vld[0]), 32'h0);
      go(2);
      @(negedge clk);
      check("rejump_addr", 0, iaddr[0], 32'h200);
      go(4);

      // Reset mid-stream with entries queued and one in flight
      ready = 1'b0;
      go(2);
      rst_n = 1'b0;
      go(1);
      rst_n = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) check("mrst_vld", k, 32'(vld[k]), 32'h0);
      go(3);
      @(negedge clk);
      for (int k = 0; k < 3; k++) check("mrst_first_addr", k, iaddr[k], 32'h0);
      go(1);
      @(negedge clk);
      for (int k = 0; k < 3; k++) check("mrst_second_addr", k, iaddr[k], 32'h4);
      go(2);

      // pc wrap at the top of the address space
      jump  = 1'b1;
      jaddr = 32'hFFFF_FFF9;
      go(1);
      jump = 1'b0;
      @(negedge clk);
      check("wrap_pc0", 0, pc[0], 32'hFFFF_FFF8);
      go(2);
      @(negedge clk);
      check("wrap_pc2", 0, pc[0], 32'h0);
      check("wrap_addr2", 0, iaddr[0], 32'hFFFF_FFF8);
      go(1);
      @(negedge clk);
      check("wrap_addr3", 0, iaddr[0], 32'hFFFF_FFFC);
      go(1);
      @(negedge clk);
      check("wrap_addr4", 0, iaddr[0], 32'h0);
      go(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Parametrised instruction-fetch front end that replaces the single-register fetch stage of the core. It issues sequential fetch requests on the instruction bus, holds returned instructions in a DEPTH-entry prefetch queue, and presents them with their addresses to the decode stage under a valid/ready handshake. Jumps from the execute stage flush the queue and discard any in-flight response. The unit sits between the instruction ROM/bus and ID_UNIT in the core top.

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch queue entries; legal range 2..16
- RESET_PC, 0, first fetch address after reset; low 2 bits must be 0

- clk  in  1  core clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- fetch_req_o  out  1  fetch request valid
- fetch_gnt_i  in  1  bus accepts request this cycle; 0 = bus hold
- pc_o  out  ADDR_W  fetch address, valid with fetch_req_o
- ins_i  in  DATA_W  instruction data, fixed 1 cycle after an accepted request
- ins_valid_o  out  1  queue head valid
- ins_ready_i  in  1  decode consumes head; 0 = pipeline hold
- ins_o  out  DATA_W  head instruction; INST_NOP (32'h0000_0013) when not valid
- ins_addr_o  out  ADDR_W  head instruction address; 0 when not valid
- jump_flag_i  in  1  redirect request from execute
- jump_addr_i  in  ADDR_W  redirect target; bits [1:0] ignored, treated as 0

## Operation
- Accept: fetch_req_o & fetch_gnt_i. On accept, pc advances by 4; one request in flight recorded with its address.
- Response: ins_i captured the cycle after accept and pushed with recorded address, unless dropped (see jump).
- Issue rule: fetch_req_o = 1 when no jump this cycle and (count + inflight < DEPTH, or count + inflight == DEPTH and a pop occurs this cycle). Push therefore never overflows.
- Pop: ins_valid_o & ins_ready_i & ~jump_flag_i.
- Push and pop in the same cycle: count unchanged, both take effect.
- Jump (jump_flag_i = 1): queue cleared at clock edge; pc loads {jump_addr_i[ADDR_W-1:2],2'b00}; fetch_req_o forced 0 in the jump cycle; any response arriving in the jump cycle or resulting from a request accepted in the jump cycle is dropped (no such request exists because fetch_req_o=0). Pop suppressed in jump cycle.
- Jump held for several cycles: every cycle re-clears queue and reloads pc; fetching resumes the first cycle jump_flag_i is 0.
- pc wraps modulo 2^ADDR_W; no error.
- Queue head drives ins_o / ins_addr_o combinationally from storage; no reordering.

## Timing
- Reset (rst_n=0 at an edge): count=0, inflight=0, pc_o=RESET_PC, fetch_req_o=0, ins_valid_o=0, ins_o=INST_NOP, ins_addr_o=0. Reset mid-operation discards queue and in-flight response identically.
- First request asserted the cycle after rst_n deasserts.
- Fetch-to-decode latency: accept at cycle t, ins_i at t+1, ins_valid_o at t+2.
- Jump at cycle t: pc_o = target with fetch_req_o=1 at t+1; target instruction valid earliest t+3.
- Sustained throughput 1 instruction/cycle when fetch_gnt_i and ins_ready_i held 1 (any DEPTH ≥ 2).
- fetch_gnt_i low: pc_o and fetch_req_o held stable until accepted or a jump occurs.

## Structure
- Shared package core_pkg: INST_NOP, ADDR_W/DATA_W defaults, RESET_PC default.
- Sub-module pf_fifo: synchronous DEPTH-entry FIFO of {addr,data} with push, pop, flush, count; pointers wrap modulo DEPTH, count width $clog2(DEPTH+1).
- Top holds pc register, inflight bit plus in-flight address, issue/flush logic.

## Test plan
- Reset: hold rst_n=0 3 cycles -> all outputs at reset values; cycle after release fetch_req_o=1, pc_o=0.
- Streaming: gnt=1, ready=1, ROM data = address -> ins_addr_o 0,4,8,... one per cycle from cycle 3 with ins_o matching; no bubbles.
- Decode hold: ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries fill, fetch_req_o drops, pc_o=16; release -> 0,4,8,12,16 in order, none lost or duplicated.
- Bus hold: gnt=0 cycles 2..5 -> pc_o stays 4 and fetch_req_o stays 1; stream resumes with no gap in addresses.
- Jump with in-flight request and full queue: jump_flag_i=1, jump_addr_i=0x103 -> next cycle queue empty, pc_o=0x100; stale response never appears; first valid ins_addr_o=0x100.
- Reset mid-stream with 3 entries queued and one in flight -> after release, first ins_addr_o = RESET_PC; no stale entry emerges; repeat with DEPTH=2 and DEPTH=16.
